// File: rtl/bcd_scan_display.sv
// Tens-digit tracker and 2-digit multiplexed 7-segment driver fed by a mod-10 units counter.
// Seg/An are registered together from the pre-edge slot, units and tens values.
module bcd_scan_display #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned TENS_MOD       = 10,
  parameter int unsigned BLANK_LEADING  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic       clk_50M,
  input  logic       Reset,
  input  logic [3:0] Digit,
  input  logic       Clear,
  output logic [6:0] Seg,
  output logic [1:0] An,
  output logic [3:0] Tens,
  output logic       Overflow
);

  localparam int unsigned CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [6:0]  SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0]  TENS_MAX = 4'(TENS_MOD - 1);

  logic [3:0]       units_q;
  logic [3:0]       tens;
  logic [CNT_W-1:0] refresh_cnt;
  logic             sel;
  logic             wrap_c;
  logic [6:0]       seg_c;
  logic [1:0]       an_c;

  // Active-high gfedcba glyphs; anything above 9 renders as a dash.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h40;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? ~g : g;
  endfunction

  assign wrap_c = (units_q == 4'd9) && (Digit == 4'd0);
  assign Tens   = tens;

  // Units sample and tens update; Clear outranks a simultaneous wrap.
  always_ff @(posedge clk_50M or negedge Reset) begin
    if (!Reset) begin
      units_q  <= 4'd0;
      tens     <= 4'd0;
      Overflow <= 1'b0;
    end else begin
      units_q <= Digit;
      if (Clear) begin
        tens     <= 4'd0;
        Overflow <= 1'b0;
      end else if (wrap_c && (tens == TENS_MAX)) begin
        tens     <= 4'd0;
        Overflow <= 1'b1;
      end else if (wrap_c) begin
        tens     <= tens + 4'd1;
        Overflow <= 1'b0;
      end else begin
        Overflow <= 1'b0;
      end
    end
  end

  // Slot timer: sel flips each time the refresh counter reaches its terminal count.
  always_ff @(posedge clk_50M or negedge Reset) begin
    if (!Reset) begin
      refresh_cnt <= '0;
      sel         <= 1'b0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      sel         <= ~sel;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    seg_c = SEG_OFF;
    an_c  = 2'b11;
    if (!sel) begin
      an_c  = 2'b10;
      seg_c = enc(units_q);
    end else if (!((BLANK_LEADING != 0) && (tens == 4'd0))) begin
      an_c  = 2'b01;
      seg_c = enc(tens);
    end
  end

  // Segments and anodes change on the same edge to avoid ghosting.
  always_ff @(posedge clk_50M or negedge Reset) begin
    if (!Reset) begin
      Seg <= SEG_OFF;
      An  <= 2'b11;
    end else begin
      Seg <= seg_c;
      An  <= an_c;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed bench for bcd_scan_display against an edge-count based reference model.
module tb_bcd_scan_display;

  localparam int RDIV = 4;
  localparam int TMOD = 10;
  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk_50M;
  logic       Reset;
  logic [3:0] Digit;
  logic       Clear;
  logic [6:0] Seg;
  logic [1:0] An;
  logic [3:0] Tens;
  logic       Overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: last sampled digit, tens count, overflow flag, edges since reset.
  int m_units, m_tens, m_ovf, m_k;
  logic [6:0] exp_seg;
  logic [1:0] exp_an;
  logic [3:0] exp_tens;
  logic       exp_ovf;

  bcd_scan_display #(
    .REFRESH_DIV(RDIV), .TENS_MOD(TMOD), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk_50M(clk_50M), .Reset(Reset), .Digit(Digit), .Clear(Clear),
    .Seg(Seg), .An(An), .Tens(Tens), .Overflow(Overflow)
  );

  initial begin
    clk_50M = 1'b0;
    forever #5 clk_50M = ~clk_50M;
  end

  function automatic logic [6:0] lit(input int v);
    logic [6:0] g;
    g = (v > 9) ? 7'h40 : GLYPH[v];
    return ~g;
  endfunction

  task automatic model_reset();
    m_units = 0; m_tens = 0; m_ovf = 0; m_k = 0;
  endtask

  // Apply one input cycle and compute what the display should show after that edge.
  task automatic drive(input int d, input logic c);
    int slot;
    @(negedge clk_50M);
    Digit = 4'(d);
    Clear = c;
    @(posedge clk_50M);
    #1;
    slot = (m_k / RDIV) % 2;
    if (slot == 0) begin
      exp_an = 2'b10; exp_seg = lit(m_units);
    end else if (m_tens == 0) begin
      exp_an = 2'b11; exp_seg = 7'h7F;
    end else begin
      exp_an = 2'b01; exp_seg = lit(m_tens);
    end
    if (c) begin
      m_tens = 0; m_ovf = 0;
    end else if (m_units == 9 && d == 0) begin
      m_ovf  = (m_tens == TMOD - 1) ? 1 : 0;
      m_tens = (m_tens + 1) % TMOD;
    end else begin
      m_ovf = 0;
    end
    m_units  = d;
    m_k      = m_k + 1;
    exp_tens = 4'(m_tens);
    exp_ovf  = (m_ovf != 0);
  endtask

  task automatic test_reset();
    Clear = 1'b0;
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_50M);
      Digit = 4'($urandom_range(0, 15));
      Clear = 1'($urandom_range(0, 1));
      @(posedge clk_50M);
      #1;
      n_cmp++;
      if ({Seg, An, Tens, Overflow} !== {7'h7F, 2'b11, 4'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset: seg=%h an=%b tens=%0d ovf=%b, want seg=7f an=11 tens=0 ovf=0",
                 Seg, An, Tens, Overflow);
      end
    end
    Clear = 1'b0;
    @(posedge clk_50M);
    #2 Reset = 1'b1;
    model_reset();
  endtask

  task automatic test_count_step();
    for (int i = 0; i <= 10; i++) begin
      drive(i % 10, 1'b0);
      n_cmp++;
      if ({Seg, An, Tens, Overflow} !== {exp_seg, exp_an, exp_tens, exp_ovf}) begin
        n_bad++;
        $display("FAIL count_step[%0d]: seg=%h an=%b tens=%0d ovf=%b, want seg=%h an=%b tens=%0d ovf=%b",
                 i, Seg, An, Tens, Overflow, exp_seg, exp_an, exp_tens, exp_ovf);
      end
    end
    n_cmp++;
    if (Tens !== 4'd1) begin
      n_bad++;
      $display("FAIL count_step_tens: tens=%0d, want 1", Tens);
    end
  endtask

  task automatic test_overflow();
    int pulses = 0;
    int pulse_ok = 0;
    drive(0, 1'b1);
    for (int i = 0; i <= 100; i++) begin
      drive(i % 10, 1'b0);
      n_cmp++;
      if ({Seg, An, Tens, Overflow} !== {exp_seg, exp_an, exp_tens, exp_ovf}) begin
        n_bad++;
        $display("FAIL overflow_step[%0d]: seg=%h an=%b tens=%0d ovf=%b, want seg=%h an=%b tens=%0d ovf=%b",
                 i, Seg, An, Tens, Overflow, exp_seg, exp_an, exp_tens, exp_ovf);
      end
      if (Overflow === 1'b1) begin
        pulses++;
        if (i == 100 && Tens === 4'd0) pulse_ok = 1;
      end
    end
    n_cmp++;
    if (pulses != 1 || pulse_ok != 1) begin
      n_bad++;
      $display("FAIL overflow_pulse: pulses=%0d at_wrap=%0d, want 1 and 1", pulses, pulse_ok);
    end
  endtask

  task automatic test_clear_wrap();
    drive(0, 1'b1);
    for (int i = 0; i < 100; i++) drive(i % 10, 1'b0);
    n_cmp++;
    if (Tens !== 4'd9) begin
      n_bad++;
      $display("FAIL clear_wrap_pre: tens=%0d, want 9", Tens);
    end
    drive(0, 1'b1);
    n_cmp++;
    if ({Tens, Overflow} !== {4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL clear_wrap: tens=%0d ovf=%b, want tens=0 ovf=0", Tens, Overflow);
    end
  endtask

  task automatic test_blank_scan();
    int units_hits = 0, blank_hits = 0, tens_hits = 0;
    drive(5, 1'b1);
    for (int i = 0; i < 16; i++) begin
      drive(5, 1'b0);
      n_cmp++;
      if ({Seg, An, Tens, Overflow} !== {exp_seg, exp_an, exp_tens, exp_ovf}) begin
        n_bad++;
        $display("FAIL blank_scan[%0d]: seg=%h an=%b tens=%0d, want seg=%h an=%b tens=%0d",
                 i, Seg, An, Tens, exp_seg, exp_an, exp_tens);
      end
      if (An === 2'b10 && Seg === 7'h12) units_hits++;
      if (An === 2'b11 && Seg === 7'h7F) blank_hits++;
    end
    n_cmp++;
    if (units_hits != 8 || blank_hits != 8) begin
      n_bad++;
      $display("FAIL blank_alternate: units=%0d blank=%0d, want 8 and 8", units_hits, blank_hits);
    end
    for (int i = 0; i < 3; i++) begin
      drive(9, 1'b0);
      drive(0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      drive(5, 1'b0);
      if (An === 2'b01 && Seg === 7'h30) tens_hits++;
    end
    n_cmp++;
    if (tens_hits != 8 || Tens !== 4'd3) begin
      n_bad++;
      $display("FAIL tens_slot: hits=%0d tens=%0d, want 8 hits tens=3", tens_hits, Tens);
    end
  endtask

  task automatic test_invalid();
    logic [3:0] t0;
    t0 = 4'(m_tens);
    for (int i = 0; i < 9; i++) begin
      drive(12, 1'b0);
      if (i > 0 && An === 2'b10) begin
        n_cmp++;
        if (Seg !== 7'h3F) begin
          n_bad++;
          $display("FAIL invalid_dash[%0d]: seg=%h, want 3f", i, Seg);
        end
      end
    end
    drive(9, 1'b0);
    drive(12, 1'b0);
    drive(0, 1'b0);
    n_cmp++;
    if ({Tens, Overflow} !== {t0, 1'b0}) begin
      n_bad++;
      $display("FAIL invalid_nowrap: tens=%0d ovf=%b, want tens=%0d ovf=0", Tens, Overflow, t0);
    end
  endtask

  task automatic test_random();
    int d = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) d = (d + 1) % 10;
      else d = $urandom_range(0, 15);
      drive(d, ($urandom_range(0, 39) == 0));
      n_cmp++;
      if ({Seg, An, Tens, Overflow} !== {exp_seg, exp_an, exp_tens, exp_ovf}) begin
        n_bad++;
        $display("FAIL random[%0d]: seg=%h an=%b tens=%0d ovf=%b, want seg=%h an=%b tens=%0d ovf=%b",
                 i, Seg, An, Tens, Overflow, exp_seg, exp_an, exp_tens, exp_ovf);
      end
    end
  endtask

  task automatic test_reset_midscan();
    for (int i = 0; i < 15; i++) drive((i + 3) % 10, 1'b0);
    #2 Reset = 1'b0;
    #1;
    n_cmp++;
    if ({Seg, An, Tens, Overflow} !== {7'h7F, 2'b11, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_midscan: seg=%h an=%b tens=%0d ovf=%b, want seg=7f an=11 tens=0 ovf=0",
               Seg, An, Tens, Overflow);
    end
    @(posedge clk_50M);
    #2 Reset = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive(7, 1'b0);
      n_cmp++;
      if ({Seg, An, Tens, Overflow} !== {exp_seg, exp_an, exp_tens, exp_ovf}) begin
        n_bad++;
        $display("FAIL restart[%0d]: seg=%h an=%b tens=%0d, want seg=%h an=%b tens=%0d",
                 i, Seg, An, Tens, exp_seg, exp_an, exp_tens);
      end
    end
  endtask

  initial begin
    Reset = 1'b0;
    Digit = 4'd0;
    Clear = 1'b0;
    model_reset();
    test_reset();
    test_count_step();
    test_overflow();
    test_clear_wrap();
    test_blank_scan();
    test_invalid();
    test_random();
    test_reset_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
